window_acc: RTL and testbench
=============================

WINDOW_ACC -- requirements
Module: window_acc

Interface
REQ-001 SHALL have parameter size, default 8, giving the width of the sample data in bits.
REQ-002 SHALL have input Clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have input Reset, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have input start, 1 bit: request to begin a new accumulation window.
REQ-005 SHALL have input stall, 1 bit: while high, suppresses sampling for that cycle.
REQ-006 SHALL have input len, 4 bits: window length minus one (0 -> 1 sample, 15 -> 16 samples).
REQ-007 SHALL have input Datain, size bits: unsigned sample stream from the upstream adder stage's Dataout.
REQ-008 SHALL have output Acc, size+4 bits: unsigned sum of the window's samples.
REQ-009 SHALL have output Max, size bits: largest sample in the window.
REQ-010 SHALL have output busy, 1 bit: high while a window is being accumulated.
REQ-011 SHALL have output done, 1 bit: one-cycle pulse marking Acc/Max final.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and ACCUM.
REQ-013 In IDLE, a rising edge with start=1 SHALL clear Acc and Max to 0, latch len into a remaining-sample counter, and enter ACCUM.
REQ-014 In IDLE, a rising edge with start=0 SHALL hold Acc and Max unchanged.
REQ-015 In ACCUM, an edge with stall=0 SHALL add Datain to Acc, set Max to the greater of Max and Datain, and decrement the counter.
REQ-016 In ACCUM, an edge with stall=1 SHALL leave Acc, Max, the counter and the state unchanged.
REQ-017 The sample taken when the counter is 0 SHALL be the last one. That edge SHALL:
- register done=1 for exactly one cycle;
- return the FSM to IDLE.
REQ-018 Latency: with start at edge t, len=L and no stall, samples SHALL be taken at edges t+1..t+L+1, and done SHALL be high during the cycle after edge t+L+1.
REQ-019 busy SHALL equal (state==ACCUM), registered, and SHALL be low in the cycle in which done is high.
REQ-020 start asserted while in ACCUM SHALL be ignored, with no effect on the window in progress.
REQ-021 start asserted in the same cycle as done SHALL start a new window: that edge clears Acc and Max, so the final values are visible only during the done cycle.
REQ-022 Acc SHALL be size+4 bits wide, which makes overflow impossible (16 x (2^size - 1) fits); no saturation logic.
REQ-023 Acc and Max SHALL hold their final values in IDLE until the next accepted start.
REQ-024 Unsigned comparison SHALL be used for Max; a tie leaves Max unchanged.

Reset
REQ-025 Reset low SHALL immediately, regardless of Clk:
- force state to IDLE;
- clear Acc, Max and the counter to 0;
- drive busy=0 and done=0.
REQ-026 Reset asserted mid-window SHALL abandon the window, with no done pulse.
REQ-027 After Reset deasserts, the block SHALL wait in IDLE for start.

Structure
REQ-028 The FSM state encoding (IDLE, ACCUM) and the accumulator growth constant (4 guard bits) SHALL live in the shared package, for reuse by sibling stages.
REQ-029 The Max compare/update SHALL be a sub-module named max_track (size-bit unsigned register with clear and enable).
REQ-030 All other logic SHALL reside in window_acc as a single clocked process plus next-state combinational logic.

Verification
REQ-031 len=3, no stall, start at edge 0, Datain=10,20,30,40 at edges 1-4 -> after edge 4: done=1 for one cycle, Acc=100, Max=40; busy high during cycles 1-4.
REQ-032 len=15, Datain=255 constant -> Acc=4080 (0xFF0), Max=255, done 16 cycles after start, no wrap.
REQ-033 len=1, Datain=7 then 9, stall=1 on the edge carrying 9, and 9 held one extra cycle with stall=0 -> Acc=16, Max=9, done delayed one cycle.
REQ-034 len=2 window in progress, start pulsed mid-window -> ignored; Acc equals the sum of the 3 original samples and exactly one done pulse occurs.
REQ-035 Reset driven low asynchronously between edges mid-window -> Acc=0, Max=0, busy=0 immediately; no done; next start runs a correct fresh window.
REQ-036 start held high through done -> back-to-back windows; each done cycle shows its own correct Acc and Max.

Source files
------------

// File: rtl/window_acc_pkg.sv
// Shared definitions for the windowed accumulator and its sibling stages.
package window_acc_pkg;

    // Window controller states
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Guard bits on the accumulator: a 16-sample window of full-scale data cannot overflow
    localparam int unsigned ACC_GUARD_BITS = 4;

    // Width of the window-length field (length minus one)
    localparam int unsigned LEN_W = 4;

endpackage : window_acc_pkg

// File: rtl/window_acc_max_track.sv
// Running unsigned maximum register with synchronous clear and update enable.
module max_track #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] max_o
);

    logic [W-1:0] max_q;

    // Clear wins over update; a tie keeps the stored value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
        end else if (clr_i) begin
            max_q <= '0;
        end else if (en_i && (d_i > max_q)) begin
            max_q <= d_i;
        end
    end

    assign max_o = max_q;

endmodule : max_track

// File: rtl/window_acc.sv
// Accumulates a window of 1..16 unsigned samples, tracking sum and maximum,
// and pulses done for one cycle when the window's last sample is taken.
module window_acc
    import window_acc_pkg::*;
#(
    parameter int unsigned size = 8
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         start,
    input  logic                         stall,
    input  logic [LEN_W-1:0]             len,
    input  logic [size-1:0]              Datain,
    output logic [size+ACC_GUARD_BITS-1:0] Acc,
    output logic [size-1:0]              Max,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned ACC_W = size + ACC_GUARD_BITS;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             max_clr_c;
    logic             max_en_c;

    // Next-state logic: window start in IDLE, sampling and termination in ACCUM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        done_d    = 1'b0;
        max_clr_c = 1'b0;
        max_en_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d     = '0;
                    cnt_d     = len;
                    max_clr_c = 1'b1;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                // start is deliberately ignored here; only stall gates sampling
                if (!stall) begin
                    acc_d    = acc_q + ACC_W'(Datain);
                    max_en_c = 1'b1;
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ACCUM);
    end

    // Single state register for the controller, counter, sum and flags
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    max_track #(
        .W (size)
    ) u_max_track (
        .clk   (Clk),
        .rst_n (Reset),
        .clr_i (max_clr_c),
        .en_i  (max_en_c),
        .d_i   (Datain),
        .max_o (Max)
    );

    assign Acc  = acc_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : window_acc

// File: tb/tb_window_acc.sv
// Directed self-checking bench for window_acc.
module tb_window_acc;

    localparam int unsigned SZ = 8;

    logic          Clk;
    logic          Reset;
    logic          start;
    logic          stall;
    logic [3:0]    len;
    logic [SZ-1:0] Datain;
    logic [SZ+3:0] Acc;
    logic [SZ-1:0] Max;
    logic          busy;
    logic          done;

    int n_checks;
    int n_fail;

    window_acc #(.size(SZ)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .start  (start),
        .stall  (stall),
        .len    (len),
        .Datain (Datain),
        .Acc    (Acc),
        .Max    (Max),
        .busy   (busy),
        .done   (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance past one rising edge; outputs are then stable for checking
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; start = 1'b0; stall = 1'b0; len = 4'd0; Datain = '0;
        #12;
        n_checks++; if (Acc !== 12'd0)  begin n_fail++; $display("FAIL reset_acc: got %0d expected 0", Acc); end
        n_checks++; if (Max !== 8'd0)   begin n_fail++; $display("FAIL reset_max: got %0d expected 0", Max); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        @(negedge Clk);
        Reset = 1'b1;
        step(); step();
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL idle_wait_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        logic [SZ-1:0] samples [4];
        samples[0] = 8'd10; samples[1] = 8'd20; samples[2] = 8'd30; samples[3] = 8'd40;
        start = 1'b1; len = 4'd3;
        step();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1 || Acc !== 12'd0) begin n_fail++; $display("FAIL basic_start: busy=%b acc=%0d expected busy=1 acc=0", busy, Acc); end
        for (int i = 0; i < 4; i++) begin
            Datain = samples[i];
            step();
            if (i < 3) begin
                n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL basic_busy%0d: busy=%b done=%b expected 1/0", i, busy, done); end
            end
        end
        n_checks++; if (done !== 1'b1)  begin n_fail++; $display("FAIL basic_done: got %b expected 1", done); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL basic_busy_in_done: got %b expected 0", busy); end
        n_checks++; if (Acc !== 12'd100) begin n_fail++; $display("FAIL basic_acc: got %0d expected 100", Acc); end
        n_checks++; if (Max !== 8'd40)  begin n_fail++; $display("FAIL basic_max: got %0d expected 40", Max); end
        Datain = 8'd99;
        step(); step();
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL basic_done_one_cycle: got %b expected 0", done); end
        n_checks++; if (Acc !== 12'd100 || Max !== 8'd40) begin n_fail++; $display("FAIL basic_hold: acc=%0d max=%0d expected 100/40", Acc, Max); end
    endtask

    task automatic test_full_window();
        int seen;
        seen = 0;
        start = 1'b1; len = 4'd15; Datain = 8'd255;
        step();
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (done === 1'b1) begin
                seen = i;
                break;
            end
        end
        n_checks++; if (seen !== 16)     begin n_fail++; $display("FAIL full_latency: done after %0d edges expected 16", seen); end
        n_checks++; if (Acc !== 12'hFF0) begin n_fail++; $display("FAIL full_acc: got %0d expected 4080", Acc); end
        n_checks++; if (Max !== 8'd255)  begin n_fail++; $display("FAIL full_max: got %0d expected 255", Max); end
        step();
    endtask

    task automatic test_stall();
        start = 1'b1; len = 4'd1;
        step();
        start = 1'b0; Datain = 8'd7; stall = 1'b0;
        step();
        Datain = 8'd9; stall = 1'b1;
        step();
        n_checks++; if (done !== 1'b0 || Acc !== 12'd7 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_hold: done=%b acc=%0d busy=%b expected 0/7/1", done, Acc, busy); end
        stall = 1'b0;
        step();
        n_checks++; if (done !== 1'b1)   begin n_fail++; $display("FAIL stall_done: got %b expected 1", done); end
        n_checks++; if (Acc !== 12'd16)  begin n_fail++; $display("FAIL stall_acc: got %0d expected 16", Acc); end
        n_checks++; if (Max !== 8'd9)    begin n_fail++; $display("FAIL stall_max: got %0d expected 9", Max); end
        step();
    endtask

    task automatic test_start_ignored();
        int dones;
        dones = 0;
        start = 1'b1; len = 4'd2;
        step();
        start = 1'b0; Datain = 8'd5;
        step();
        start = 1'b1; len = 4'd9; Datain = 8'd7;
        step();
        start = 1'b0; Datain = 8'd6;
        step();
        n_checks++; if (done !== 1'b1)  begin n_fail++; $display("FAIL ign_done: got %b expected 1", done); end
        n_checks++; if (Acc !== 12'd18) begin n_fail++; $display("FAIL ign_acc: got %0d expected 18", Acc); end
        n_checks++; if (Max !== 8'd7)   begin n_fail++; $display("FAIL ign_max: got %0d expected 7", Max); end
        for (int i = 0; i < 12; i++) begin
            step();
            if (done === 1'b1) dones++;
        end
        n_checks++; if (dones !== 0)    begin n_fail++; $display("FAIL ign_extra_done: got %0d extra pulses expected 0", dones); end
    endtask

    task automatic test_async_reset();
        int dones;
        dones = 0;
        start = 1'b1; len = 4'd3;
        step();
        start = 1'b0; Datain = 8'd50;
        step();
        Datain = 8'd60;
        step();
        #2;
        Reset = 1'b0;
        #1;
        n_checks++; if (Acc !== 12'd0 || Max !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: acc=%0d max=%0d busy=%b done=%b expected 0/0/0/0", Acc, Max, busy, done);
        end
        @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL async_abandon: got %0d active cycles expected 0", dones); end
        start = 1'b1; len = 4'd0; Datain = 8'd42;
        step();
        start = 1'b0;
        step();
        n_checks++; if (done !== 1'b1 || Acc !== 12'd42 || Max !== 8'd42) begin
            n_fail++; $display("FAIL async_fresh: done=%b acc=%0d max=%0d expected 1/42/42", done, Acc, Max);
        end
        step();
    endtask

    task automatic test_back_to_back();
        start = 1'b1; len = 4'd1; Datain = 8'd0;
        step();
        Datain = 8'd3;
        step();
        Datain = 8'd8;
        step();
        n_checks++; if (done !== 1'b1 || Acc !== 12'd11 || Max !== 8'd8) begin
            n_fail++; $display("FAIL b2b_first: done=%b acc=%0d max=%0d expected 1/11/8", done, Acc, Max);
        end
        Datain = 8'd77;
        step();
        n_checks++; if (done !== 1'b0 || busy !== 1'b1 || Acc !== 12'd0 || Max !== 8'd0) begin
            n_fail++; $display("FAIL b2b_restart: done=%b busy=%b acc=%0d max=%0d expected 0/1/0/0", done, busy, Acc, Max);
        end
        Datain = 8'd20;
        step();
        Datain = 8'd1;
        step();
        n_checks++; if (done !== 1'b1 || Acc !== 12'd21 || Max !== 8'd20) begin
            n_fail++; $display("FAIL b2b_second: done=%b acc=%0d max=%0d expected 1/21/20", done, Acc, Max);
        end
        start = 1'b0;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_full_window();
        test_stall();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_window_acc
